ps2_game_keys: RTL and testbench

- Upstream neighbour of the game-control logic. Consumes the byte stream from PS2_Interface (ps2_key_data plus ps2_key_pressed strobe) and decodes make/break (F0) and extended (E0) prefixes.
- Tracks which game keys are held and drives active-low held levels plus one-cycle move pulses, with internal auto-repeat for left/right/down.
- Also emits the ASCII of the last pressed key for the LCD and seven-segment path.

---
 rtl/ps2_game_keys.sv | 182 ++++++++++++++++++
 tb/tb_ps2_game_keys.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_game_keys.sv
// PS/2 scan-code decoder for the game controls: tracks held keys, emits move pulses
// with auto-repeat on left/right/down, and reports the ASCII of the last pressed key.
module ps2_game_keys #(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int CNT_W        = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    output logic       key_left_n,
    output logic       key_right_n,
    output logic       key_up_n,
    output logic       key_down_n,
    output logic       slow1_n,
    output logic       slow2_n,
    output logic [3:0] move_pulse,
    output logic [7:0] ascii_out,
    output logic       ascii_valid
);

    // Key indices: 0 left, 1 right, 2 up, 3 down, 4 slow1 (M), 5 slow2 (O).
    // Indices 0..3 line up with the move_pulse bit positions.
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

    logic             brk_reg;
    logic             ext_reg;
    logic [5:0]       held_n_reg;
    logic [5:0]       held_n_next;
    logic [3:0]       pulse_reg;
    logic [3:0]       pulse_next;
    logic [7:0]       ascii_reg;
    logic             ascii_valid_reg;
    logic             rep_active_reg;
    logic             rep_active_next;
    logic [1:0]       rep_idx_reg;
    logic [1:0]       rep_idx_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    logic       is_prefix;
    logic       final_strobe;
    logic       key_mapped;
    logic [2:0] key_idx;
    logic [7:0] key_ascii;
    logic       hit;
    logic       make_hit;
    logic       break_hit;
    logic       already_held;
    logic       new_make;
    logic       is_rep_key;
    logic [5:0] key_sel;

    assign is_prefix    = (ps2_key_data == 8'hF0) || (ps2_key_data == 8'hE0);
    assign final_strobe = ps2_key_pressed && !is_prefix;

    always_comb begin
        key_mapped = 1'b1;
        key_idx    = 3'd0;
        if (!ext_reg) begin
            case (ps2_key_data)
                8'h1B:   key_idx = 3'd0;
                8'h2B:   key_idx = 3'd1;
                8'h24:   key_idx = 3'd2;
                8'h23:   key_idx = 3'd3;
                8'h3A:   key_idx = 3'd4;
                8'h44:   key_idx = 3'd5;
                default: key_mapped = 1'b0;
            endcase
        end else begin
            case (ps2_key_data)
                8'h6B:   key_idx = 3'd0;
                8'h74:   key_idx = 3'd1;
                8'h75:   key_idx = 3'd2;
                8'h72:   key_idx = 3'd3;
                default: key_mapped = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (key_idx)
            3'd0:    key_ascii = 8'h73;
            3'd1:    key_ascii = 8'h66;
            3'd2:    key_ascii = 8'h65;
            3'd3:    key_ascii = 8'h64;
            3'd4:    key_ascii = 8'h6D;
            3'd5:    key_ascii = 8'h6F;
            default: key_ascii = 8'h00;
        endcase
    end

    assign hit          = final_strobe && key_mapped;
    assign make_hit     = hit && !brk_reg;
    assign break_hit    = hit && brk_reg;
    assign already_held = !held_n_reg[key_idx];
    assign new_make     = make_hit && !already_held;
    assign is_rep_key   = (key_idx == 3'd0) || (key_idx == 3'd1) || (key_idx == 3'd3);
    assign key_sel      = hit ? (6'd1 << key_idx) : 6'd0;

    // A make drives the held level low (brk=0), a break drives it high (brk=1).
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_held
            assign held_n_next[gi] = key_sel[gi] ? brk_reg : held_n_reg[gi];
        end
    endgenerate

    // Any resolved make/break takes priority over a repeat expiry in the same cycle.
    always_comb begin
        rep_active_next = rep_active_reg;
        rep_idx_next    = rep_idx_reg;
        cnt_next        = cnt_reg;
        pulse_next      = 4'd0;
        if (new_make && is_rep_key) begin
            rep_active_next = 1'b1;
            rep_idx_next    = key_idx[1:0];
            cnt_next        = DELAY_LOAD;
        end else if (break_hit && rep_active_reg && (key_idx == {1'b0, rep_idx_reg})) begin
            rep_active_next = 1'b0;
            cnt_next        = '0;
        end else if (rep_active_reg) begin
            if (cnt_reg == '0) begin
                cnt_next = RATE_LOAD;
                if (!hit) begin
                    pulse_next[rep_idx_reg] = 1'b1;
                end
            end else begin
                cnt_next = cnt_reg - CNT_W'(1);
            end
        end
        if (new_make && !key_idx[2]) begin
            pulse_next[key_idx[1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            brk_reg         <= 1'b0;
            ext_reg         <= 1'b0;
            held_n_reg      <= 6'b111111;
            pulse_reg       <= 4'd0;
            ascii_reg       <= 8'h00;
            ascii_valid_reg <= 1'b0;
            rep_active_reg  <= 1'b0;
            rep_idx_reg     <= 2'd0;
            cnt_reg         <= '0;
        end else begin
            if (ps2_key_pressed) begin
                if (ps2_key_data == 8'hF0) begin
                    brk_reg <= 1'b1;
                end else if (ps2_key_data == 8'hE0) begin
                    ext_reg <= 1'b1;
                end else begin
                    brk_reg <= 1'b0;
                    ext_reg <= 1'b0;
                end
            end
            held_n_reg      <= held_n_next;
            pulse_reg       <= pulse_next;
            ascii_valid_reg <= make_hit;
            if (make_hit) begin
                ascii_reg <= key_ascii;
            end
            rep_active_reg <= rep_active_next;
            rep_idx_reg    <= rep_idx_next;
            cnt_reg        <= cnt_next;
        end
    end

    assign key_left_n  = held_n_reg[0];
    assign key_right_n = held_n_reg[1];
    assign key_up_n    = held_n_reg[2];
    assign key_down_n  = held_n_reg[3];
    assign slow1_n     = held_n_reg[4];
    assign slow2_n     = held_n_reg[5];
    assign move_pulse  = pulse_reg;
    assign ascii_out   = ascii_reg;
    assign ascii_valid = ascii_valid_reg;

endmodule

// File: tb/tb_ps2_game_keys.sv
// Directed bench for ps2_game_keys: a vector table for decoding plus hand sequences
// for auto-repeat timing, repeat takeover, strobe/expiry collision and mid-prefix reset.
module tb_ps2_game_keys;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ps2_key_data = 8'h00;
    logic       ps2_key_pressed = 1'b0;
    logic       key_left_n, key_right_n, key_up_n, key_down_n, slow1_n, slow2_n;
    logic [3:0] move_pulse;
    logic [7:0] ascii_out;
    logic       ascii_valid;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_game_keys #(.REPEAT_DELAY(10), .REPEAT_RATE(4), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .ps2_key_data(ps2_key_data), .ps2_key_pressed(ps2_key_pressed),
        .key_left_n(key_left_n), .key_right_n(key_right_n),
        .key_up_n(key_up_n), .key_down_n(key_down_n),
        .slow1_n(slow1_n), .slow2_n(slow2_n),
        .move_pulse(move_pulse), .ascii_out(ascii_out), .ascii_valid(ascii_valid)
    );

    always #5 clock = ~clock;

    // held order {left, right, up, down, slow1, slow2}; 1 = released
    typedef struct {
        logic       strobe;
        logic [7:0] data;
        logic [5:0] held_n;
        logic [3:0] pulse;
        logic [7:0] ascii;
        logic       valid;
    } vec_t;

    vec_t vecs[64];
    int   n_vec = 0;

    function automatic logic [18:0] outs();
        return {key_left_n, key_right_n, key_up_n, key_down_n, slow1_n, slow2_n,
                move_pulse, ascii_out, ascii_valid};
    endfunction

    task automatic add(input logic s, input logic [7:0] d, input logic [5:0] h,
                       input logic [3:0] p, input logic [7:0] a, input logic v);
        vecs[n_vec] = '{s, d, h, p, a, v};
        n_vec++;
    endtask

    task automatic chk(input string name, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_pulse(input string name, input int k, input logic [3:0] exp);
        n_checks++;
        if (move_pulse !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d: move_pulse got %b expected %b", name, k, move_pulse, exp);
        end
    endtask

    task automatic step(input logic s, input logic [7:0] d);
        @(negedge clock);
        ps2_key_pressed = s;
        ps2_key_data    = d;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        ps2_key_pressed = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    localparam logic [18:0] RESET_OUTS = {6'b111111, 4'b0000, 8'h00, 1'b0};

    initial begin
        add(1, 8'h1B, 6'b011111, 4'b0001, 8'h73, 1);
        add(0, 8'h00, 6'b011111, 4'b0000, 8'h73, 0);
        add(1, 8'hF0, 6'b011111, 4'b0000, 8'h73, 0);
        add(1, 8'h1B, 6'b111111, 4'b0000, 8'h73, 0);
        add(1, 8'hE0, 6'b111111, 4'b0000, 8'h73, 0);
        add(1, 8'h75, 6'b110111, 4'b0100, 8'h65, 1);
        add(1, 8'hE0, 6'b110111, 4'b0000, 8'h65, 0);
        add(1, 8'h75, 6'b110111, 4'b0000, 8'h65, 1);
        add(1, 8'hE0, 6'b110111, 4'b0000, 8'h65, 0);
        add(1, 8'hF0, 6'b110111, 4'b0000, 8'h65, 0);
        add(1, 8'h75, 6'b111111, 4'b0000, 8'h65, 0);
        add(1, 8'h3A, 6'b111101, 4'b0000, 8'h6D, 1);
        add(1, 8'h44, 6'b111100, 4'b0000, 8'h6F, 1);
        add(1, 8'h5A, 6'b111100, 4'b0000, 8'h6F, 0);
        add(1, 8'hF0, 6'b111100, 4'b0000, 8'h6F, 0);
        add(1, 8'h3A, 6'b111110, 4'b0000, 8'h6F, 0);
        add(1, 8'hF0, 6'b111110, 4'b0000, 8'h6F, 0);
        add(1, 8'h44, 6'b111111, 4'b0000, 8'h6F, 0);
        add(1, 8'hE0, 6'b111111, 4'b0000, 8'h6F, 0);
        add(1, 8'h6B, 6'b011111, 4'b0001, 8'h73, 1);
        add(1, 8'hE0, 6'b011111, 4'b0000, 8'h73, 0);
        add(1, 8'hF0, 6'b011111, 4'b0000, 8'h73, 0);
        add(1, 8'h6B, 6'b111111, 4'b0000, 8'h73, 0);
        add(1, 8'hE0, 6'b111111, 4'b0000, 8'h73, 0);
        add(1, 8'h74, 6'b101111, 4'b0010, 8'h66, 1);
        add(1, 8'hF0, 6'b101111, 4'b0000, 8'h66, 0);
        add(1, 8'h2B, 6'b111111, 4'b0000, 8'h66, 0);
        add(1, 8'hE0, 6'b111111, 4'b0000, 8'h66, 0);
        add(1, 8'h72, 6'b111011, 4'b1000, 8'h64, 1);
        add(1, 8'hE0, 6'b111011, 4'b0000, 8'h64, 0);
        add(1, 8'hF0, 6'b111011, 4'b0000, 8'h64, 0);
        add(1, 8'h72, 6'b111111, 4'b0000, 8'h64, 0);
        add(1, 8'hE0, 6'b111111, 4'b0000, 8'h64, 0);
        add(1, 8'h1B, 6'b111111, 4'b0000, 8'h64, 0);
        add(1, 8'h24, 6'b110111, 4'b0100, 8'h65, 1);
        add(1, 8'hF0, 6'b110111, 4'b0000, 8'h65, 0);
        add(1, 8'h24, 6'b111111, 4'b0000, 8'h65, 0);
        add(0, 8'h1B, 6'b111111, 4'b0000, 8'h65, 0);
        add(1, 8'h2B, 6'b101111, 4'b0010, 8'h66, 1);
        add(1, 8'h23, 6'b101011, 4'b1000, 8'h64, 1);
        add(1, 8'hF0, 6'b101011, 4'b0000, 8'h64, 0);
        add(1, 8'h2B, 6'b111011, 4'b0000, 8'h64, 0);
        add(1, 8'hF0, 6'b111011, 4'b0000, 8'h64, 0);
        add(1, 8'h23, 6'b111111, 4'b0000, 8'h64, 0);

        // reset values
        repeat (3) @(negedge clock);
        chk("reset_outs", outs(), RESET_OUTS);
        reset = 1'b0;

        for (int i = 0; i < n_vec; i++) begin
            step(vecs[i].strobe, vecs[i].data);
            $display("vec %0d strobe=%0b data=%h -> outs=%h", i, vecs[i].strobe, vecs[i].data, outs());
            chk($sformatf("vec%0d", i), outs(),
                {vecs[i].held_n, vecs[i].pulse, vecs[i].ascii, vecs[i].valid});
        end

        // auto-repeat timing on held S, break lands on an expiry cycle
        do_reset();
        step(1, 8'h1B);
        chk_pulse("rep_make", 0, 4'b0001);
        for (int k = 1; k <= 20; k++) begin
            step(0, 8'h00);
            chk_pulse("rep_hold", k, (k == 10 || k == 14 || k == 18) ? 4'b0001 : 4'b0000);
        end
        step(1, 8'hF0);
        chk_pulse("rep_f0", 21, 4'b0000);
        step(1, 8'h1B);
        chk_pulse("rep_break", 22, 4'b0000);
        chk("rep_break_left", {18'd0, key_left_n}, 19'd1);
        for (int k = 23; k <= 34; k++) begin
            step(0, 8'h00);
            chk_pulse("rep_after_break", k, 4'b0000);
        end
        $display("seq repeat done");

        // right make, then down takes over before right's first repeat
        do_reset();
        step(1, 8'h2B);
        chk_pulse("take_right", 0, 4'b0010);
        for (int k = 1; k <= 4; k++) begin
            step(0, 8'h00);
            chk_pulse("take_idle", k, 4'b0000);
        end
        step(1, 8'h23);
        chk_pulse("take_down", 5, 4'b1000);
        step(0, 8'h00);
        step(1, 8'hF0);
        step(1, 8'h2B);
        chk_pulse("take_brk_right", 8, 4'b0000);
        chk("take_held", {13'd0, key_left_n, key_right_n, key_up_n, key_down_n, slow1_n, slow2_n},
            {13'd0, 6'b111011});
        for (int k = 9; k <= 16; k++) begin
            step(0, 8'h00);
            chk_pulse("take_rep", k, (k == 15) ? 4'b1000 : 4'b0000);
        end
        $display("seq takeover done");

        // make of D on the exact left expiry cycle, then an unmapped code
        do_reset();
        step(1, 8'h1B);
        chk_pulse("col_make", 0, 4'b0001);
        for (int k = 1; k <= 9; k++) begin
            step(0, 8'h00);
            chk_pulse("col_idle", k, 4'b0000);
        end
        step(1, 8'h23);
        chk_pulse("col_hit", 10, 4'b1000);
        for (int k = 11; k <= 20; k++) begin
            step(0, 8'h00);
            chk_pulse("col_rep", k, (k == 20) ? 4'b1000 : 4'b0000);
        end
        step(1, 8'h5A);
        chk("col_unmapped", outs(), {6'b011011, 4'b0000, 8'h64, 1'b0});
        $display("seq collision done");

        // reset in the middle of a break prefix
        do_reset();
        step(1, 8'hF0);
        @(negedge clock);
        ps2_key_pressed = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("mid_reset_outs", outs(), RESET_OUTS);
        reset = 1'b0;
        step(1, 8'h3A);
        chk("mid_reset_make", outs(), {6'b111101, 4'b0000, 8'h6D, 1'b1});
        $display("seq mid-reset done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
